// File: rtl/shape_pkg.sv
// Shared types for the shape rasteriser:
// FSM state encoding and draw-mode codes.
package shape_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] MODE_SPRITE = 2'd0;
  localparam logic [1:0] MODE_TRANSP = 2'd1;
  localparam logic [1:0] MODE_SOLID  = 2'd2;
  localparam logic [1:0] MODE_ERASE  = 2'd3;

endpackage

// File: rtl/shape_raster_engine_raster_counter.sv
// Row-major pixel walker: xc/yc plus a running ROM address.
// Ports: clear/advance controls, w/h extents, xc/yc/addr, last flag.
module raster_counter #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [X_W-1:0]    w,
  input  logic [Y_W-1:0]    h,
  output logic [X_W-1:0]    xc,
  output logic [Y_W-1:0]    yc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic row_end;

  assign row_end = (xc == w - X_W'(1));
  assign last    = row_end && (yc == h - Y_W'(1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      xc   <= '0;
      yc   <= '0;
      addr <= '0;
    end else if (advance) begin
      // Running increment keeps addr == yc*w+xc
      // without a multiplier.
      addr <= addr + ADDR_W'(1);
      if (row_end) begin
        xc <= '0;
        yc <= yc + Y_W'(1);
      end else begin
        xc <= xc + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/shape_raster_engine.sv
// Rectangle/sprite rasteriser driving a plot/ready pixel port.
// Ports: start+command in, sprite ROM addr/data, pixel out, status.
module shape_raster_engine
  import shape_pkg::*;
#(
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int C_W        = 3,
  parameter int MAX_W      = 64,
  parameter int MAX_H      = 64,
  parameter int ADDR_W     = 12,
  parameter int TRANSP_KEY = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    x_base,
  input  logic [Y_W-1:0]    y_base,
  input  logic [X_W-1:0]    width_in,
  input  logic [Y_W-1:0]    height_in,
  input  logic [1:0]        mode,
  input  logic [C_W-1:0]    color_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [C_W-1:0]    rom_data,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [C_W-1:0]    color_out,
  output logic              plot,
  input  logic              plot_ready,
  output logic              ready_cmd,
  output logic              busy,
  output logic              done
);

  state_t           state;
  logic [X_W-1:0]   xb;
  logic [Y_W-1:0]   yb;
  logic [X_W-1:0]   w;
  logic [Y_W-1:0]   h;
  logic [1:0]       md;
  logic [C_W-1:0]   col;
  logic [X_W-1:0]   w_clamp;
  logic [Y_W-1:0]   h_clamp;
  logic [X_W-1:0]   xc;
  logic [Y_W-1:0]   yc;
  logic [C_W-1:0]   pix;
  logic             last;
  logic             in_write;
  logic             transp;
  logic             advance;
  logic             clear;

  assign w_clamp = (width_in > X_W'(MAX_W))
                 ? X_W'(MAX_W) : width_in;
  assign h_clamp = (height_in > Y_W'(MAX_H))
                 ? Y_W'(MAX_H) : height_in;

  assign in_write = (state == WRITE);
  assign transp   = (md == MODE_TRANSP)
                 && (rom_data == C_W'(TRANSP_KEY));
  // A transparent pixel never waits on the adapter.
  assign advance  = in_write && (transp || plot_ready);
  assign clear    = (state == IDLE) && start;

  assign plot      = in_write && !transp;
  assign ready_cmd = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    pix = '0;
    unique case (md)
      MODE_SPRITE: pix = rom_data;
      MODE_TRANSP: pix = rom_data;
      MODE_SOLID:  pix = col;
      MODE_ERASE:  pix = '0;
      default:     pix = '0;
    endcase
  end

  // ROM data only stays valid while addr is held, so the
  // colour is steered straight from it during WRITE.
  assign color_out = in_write ? pix : '0;

  raster_counter #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .advance(advance),
    .w      (w),
    .h      (h),
    .xc     (xc),
    .yc     (yc),
    .addr   (rom_addr),
    .last   (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      xb    <= '0;
      yb    <= '0;
      w     <= '0;
      h     <= '0;
      md    <= '0;
      col   <= '0;
      x_out <= '0;
      y_out <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            xb  <= x_base;
            yb  <= y_base;
            w   <= w_clamp;
            h   <= h_clamp;
            md  <= mode;
            col <= color_in;
            if (w_clamp == '0 || h_clamp == '0)
              state <= DONE;
            else
              state <= FETCH;
          end
        end
        FETCH: begin
          // Coordinates wrap; no clipping.
          x_out <= xb + xc;
          y_out <= yb + yc;
          state <= WRITE;
        end
        WRITE: begin
          if (advance)
            state <= last ? DONE : FETCH;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_raster_engine.sv
// Bench for shape_raster_engine: table of shapes, random shapes,
// reset abort and busy-start sequences against a pixel-list model.
module tb_shape_raster_engine;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  x_base;
  logic [6:0]  y_base;
  logic [7:0]  width_in;
  logic [6:0]  height_in;
  logic [1:0]  mode;
  logic [2:0]  color_in;
  logic [11:0] rom_addr;
  logic [2:0]  rom_data;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  color_out;
  logic        plot;
  logic        plot_ready;
  logic        ready_cmd;
  logic        busy;
  logic        done;

  shape_raster_engine dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x_base    (x_base),
    .y_base    (y_base),
    .width_in  (width_in),
    .height_in (height_in),
    .mode      (mode),
    .color_in  (color_in),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .x_out     (x_out),
    .y_out     (y_out),
    .color_out (color_out),
    .plot      (plot),
    .plot_ready(plot_ready),
    .ready_cmd (ready_cmd),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] rom_mem [0:4095];
  always @(posedge clock) rom_data <= rom_mem[rom_addr];

  int n_chk;
  int n_fail;

  typedef struct {
    int xb; int yb; int w; int h;
    int mode; int col;
    int stall; int poke;
    int exp_plots; int exp_done;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name,
                       input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int pk(input int x, input int y,
                            input int c);
    return (x << 10) | (y << 3) | c;
  endfunction

  task automatic run_shape(input vec_t v, input int id);
    int exp_q[$];
    int act_q[$];
    int w, h, a, c, cc, done_c, acc, stall_n;
    int pend_pix, pix, n;
    bit pend;
    w = (v.w > 64) ? 64 : v.w;
    h = (v.h > 64) ? 64 : v.h;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        a = yy * w + xx;
        case (v.mode)
          0, 1:    cc = int'(rom_mem[a]);
          2:       cc = v.col;
          default: cc = 0;
        endcase
        if (!(v.mode == 1 && cc == 0))
          exp_q.push_back(pk((v.xb + xx) % 256,
                             (v.yb + yy) % 128, cc));
      end
    @(negedge clock);
    x_base     = 8'(v.xb);
    y_base     = 7'(v.yb);
    width_in   = 8'(v.w);
    height_in  = 7'(v.h);
    mode       = 2'(v.mode);
    color_in   = 3'(v.col);
    start      = 1'b1;
    plot_ready = 1'b1;
    c = 0; done_c = -1; acc = 0;
    stall_n = 0; pend = 0; pend_pix = 0;
    while (c < 3000 && done_c < 0) begin
      @(negedge clock);
      c++;
      if (c == 1) begin
        start = 1'b0;
        check($sformatf("busy_%0d", id), int'(busy), 1);
        check($sformatf("rdy_%0d", id), int'(ready_cmd), 0);
      end
      if (v.poke != 0 && c == 3) begin
        start    = 1'b1;
        x_base   = 8'd99;
        width_in = 8'd5;
      end
      if (v.poke != 0 && c == 4) start = 1'b0;
      pix = pk(int'(x_out), int'(y_out), int'(color_out));
      if (pend)
        check($sformatf("hold_%0d", id),
              plot ? pix : -1, pend_pix);
      if (done) begin
        done_c = c;
      end else begin
        case (v.stall)
          1: plot_ready = ($urandom_range(0, 2) != 0);
          2: begin
            if (plot && acc == 1 && stall_n < 5) begin
              plot_ready = 1'b0;
              stall_n++;
            end else begin
              plot_ready = 1'b1;
            end
          end
          default: plot_ready = 1'b1;
        endcase
        pend = 0;
        if (plot && plot_ready) begin
          act_q.push_back(pix);
          acc++;
        end else if (plot) begin
          pend = 1;
          pend_pix = pix;
        end
      end
    end
    if (done_c < 0)
      check($sformatf("timeout_%0d", id), 0, 1);
    @(negedge clock);
    check($sformatf("pulse_%0d", id), int'(done), 0);
    check($sformatf("nplot_%0d", id),
          act_q.size(), exp_q.size());
    if (v.exp_plots >= 0)
      check($sformatf("tplot_%0d", id),
            act_q.size(), v.exp_plots);
    n = (act_q.size() < exp_q.size())
      ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("pix_%0d_%0d", id, i),
            act_q[i], exp_q[i]);
    if (v.exp_done >= 0)
      check($sformatf("dcyc_%0d", id), done_c, v.exp_done);
  endtask

  task automatic reset_abort();
    int acc, nplot, ndone;
    @(negedge clock);
    x_base = 8'd40; y_base = 7'd10;
    width_in = 8'd4; height_in = 7'd2;
    mode = 2'd2; color_in = 3'd4;
    plot_ready = 1'b1;
    start = 1'b1;
    acc = 0;
    for (int i = 0; i < 40 && acc < 3; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (plot) acc++;
    end
    check("abort_acc", acc, 3);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_plot", int'(plot), 0);
    check("abort_rdy", int'(ready_cmd), 1);
    check("abort_busy", int'(busy), 0);
    nplot = 0; ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (plot) nplot++;
      if (done) ndone++;
    end
    check("abort_nplot", nplot, 0);
    check("abort_ndone", ndone, 0);
  endtask

  initial begin
    vec_t v;
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = 3'($urandom_range(0, 7));
    rom_mem[0] = 3'd0; rom_mem[1] = 3'd3;
    rom_mem[2] = 3'd0; rom_mem[3] = 3'd6;

    tbl[0] = '{10, 5, 3, 2, 2, 5, 0, 0, 6, 14};
    tbl[1] = '{20, 30, 2, 2, 1, 0, 0, 0, 2, 10};
    tbl[2] = '{1, 1, 3, 1, 0, 0, 2, 0, 3, 13};
    tbl[3] = '{7, 7, 0, 3, 2, 1, 0, 0, 0, 2};
    tbl[4] = '{0, 0, 200, 2, 2, 6, 0, 0, 128, 258};
    tbl[5] = '{254, 3, 4, 1, 3, 7, 0, 0, 4, 10};
    tbl[6] = '{3, 100, 1, 100, 2, 2, 0, 0, 64, 130};
    tbl[7] = '{0, 0, 2, 2, 2, 2, 0, 1, 4, 10};

    reset = 1'b1; start = 1'b0;
    x_base = '0; y_base = '0;
    width_in = '0; height_in = '0;
    mode = '0; color_in = '0;
    plot_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_plot", int'(plot), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_col", int'(color_out), 0);
    check("rst_addr", int'(rom_addr), 0);
    check("rst_rdy", int'(ready_cmd), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_shape(tbl[i], i);

    reset_abort();
    run_shape(tbl[0], 100);

    for (int i = 0; i < 20; i++) begin
      v.xb    = $urandom_range(0, 255);
      v.yb    = $urandom_range(0, 127);
      v.w     = $urandom_range(0, 9);
      v.h     = $urandom_range(0, 6);
      v.mode  = $urandom_range(0, 3);
      v.col   = $urandom_range(0, 7);
      v.stall = 1;
      v.poke  = 0;
      v.exp_plots = -1;
      v.exp_done  = -1;
      run_shape(v, 200 + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
